// File: rtl/piso_serializer_pkg.sv
// Shared types and defaults for the parallel-in/serial-out serializer.
// The state encoding lives here so the top level and the sub-module use the same values.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Width of the bit counter for a word of w bits.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master modport is the upstream driver and the slave modport is the serializer.
interface piso_serializer_if
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;

    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, sout, sout_valid, sout_last, busy
    );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Counts from 0 up to WIDTH-1 and saturates there. It provides clear, enable and a
// registered terminal-count flag, so sout_last comes straight from a flop.
module bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
        tc_d = (count_d == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter. It takes a WIDTH-bit word over a valid/ready load
// and sends it one bit per shift_en cycle, with no gap between back-to-back words.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    piso_serializer_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CW-1:0]    count;
    logic             cnt_tc;
    logic             cnt_clear;
    logic             cnt_en;
    logic             ready_int;
    logic             sout_bit;

    // The output end of the shift register depends on the bit order.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
            assign sout_bit     = sreg_q[WIDTH-1];
        end else begin : g_lsb
            assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
            assign sout_bit     = sreg_q[0];
        end
    endgenerate

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .count   (count),
        .tc      (cnt_tc)
    );

    // A new word is accepted when the block is idle, or when the last bit is consumed.
    assign ready_int = (state_q == ST_IDLE) ||
                       ((state_q == ST_SHIFT) && cnt_tc && bus.shift_en);

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (bus.load_valid) begin
                    sreg_d  = bus.load_data;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.shift_en) begin
                    if (!cnt_tc) begin
                        sreg_d = sreg_shifted;
                        cnt_en = 1'b1;
                    end else begin
                        cnt_clear = 1'b1;
                        if (bus.load_valid) begin
                            sreg_d = bus.load_data;
                        end else begin
                            // Clearing the register keeps sout at 0 while idle.
                            sreg_d  = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sreg_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    assign bus.load_ready = reset_n && ready_int;
    assign bus.sout       = sout_bit;
    assign bus.sout_valid = (state_q == ST_SHIFT);
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.sout_last  = cnt_tc;

    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer. It runs an MSB-first and an
// LSB-first instance against a bit-queue reference model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         lv = 1'b0;
    logic [W-1:0] ld = '0;
    logic         se = 1'b0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if_m ();
    piso_serializer_if #(.WIDTH(W)) if_l ();

    assign if_m.load_valid = lv;
    assign if_m.load_data  = ld;
    assign if_m.shift_en   = se;
    assign if_l.load_valid = lv;
    assign if_l.load_data  = ld;
    assign if_l.shift_en   = se;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_m.slave)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_l.slave)
    );

    // Reference: the bits still to be sent, in send order; the front is on sout.
    bit q_m[$];
    bit q_l[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_dut(input string nm, input logic s, input logic v, input logic l,
                             input logic b, input logic r, input int sz, input bit head);
        check_eq({nm, ".sout"},       s, (sz > 0) ? head : 1'b0);
        check_eq({nm, ".sout_valid"}, v, sz > 0);
        check_eq({nm, ".sout_last"},  l, sz == 1);
        check_eq({nm, ".busy"},       b, sz > 0);
        check_eq({nm, ".load_ready"}, r, (sz == 0) || (sz == 1 && se));
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".m.sout"},       if_m.sout, 1'b0);
        check_eq({tag, ".m.sout_valid"}, if_m.sout_valid, 1'b0);
        check_eq({tag, ".m.sout_last"},  if_m.sout_last, 1'b0);
        check_eq({tag, ".m.busy"},       if_m.busy, 1'b0);
        check_eq({tag, ".m.load_ready"}, if_m.load_ready, 1'b0);
        check_eq({tag, ".l.sout"},       if_l.sout, 1'b0);
        check_eq({tag, ".l.sout_valid"}, if_l.sout_valid, 1'b0);
        check_eq({tag, ".l.busy"},       if_l.busy, 1'b0);
        check_eq({tag, ".l.load_ready"}, if_l.load_ready, 1'b0);
    endtask

    // Check at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        bit rdy;
        @(negedge clk);
        check_dut("msb", if_m.sout, if_m.sout_valid, if_m.sout_last, if_m.busy,
                  if_m.load_ready, q_m.size(), (q_m.size() > 0) ? q_m[0] : 1'b0);
        check_dut("lsb", if_l.sout, if_l.sout_valid, if_l.sout_last, if_l.busy,
                  if_l.load_ready, q_l.size(), (q_l.size() > 0) ? q_l[0] : 1'b0);
        $display("cyc=%0d lv=%0b ld=%02h se=%0b | m: v=%0b s=%0b l=%0b r=%0b | l: v=%0b s=%0b l=%0b r=%0b",
                 cyc, lv, ld, se, if_m.sout_valid, if_m.sout, if_m.sout_last, if_m.load_ready,
                 if_l.sout_valid, if_l.sout, if_l.sout_last, if_l.load_ready);
        @(posedge clk);
        rdy = (q_m.size() == 0) || (q_m.size() == 1 && se);
        if (se && q_m.size() > 0) void'(q_m.pop_front());
        if (se && q_l.size() > 0) void'(q_l.pop_front());
        if (lv && rdy) begin
            for (int i = W - 1; i >= 0; i--) q_m.push_back(ld[i]);
            for (int i = 0; i < W; i++)      q_l.push_back(ld[i]);
        end
        cyc++;
        #1;
    endtask

    initial begin
        // Reset state, including load_ready held low during reset.
        #3;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;

        // Single word at full rate.
        lv = 1'b1; ld = 8'hA5; se = 1'b1;
        cycle();
        lv = 1'b0;
        repeat (9) cycle();

        // A word with only the LSB set.
        lv = 1'b1; ld = 8'h01;
        cycle();
        lv = 1'b0;
        repeat (9) cycle();

        // Stall mid-word.
        lv = 1'b1; ld = 8'hF0; se = 1'b1;
        cycle();
        lv = 1'b0;
        repeat (2) cycle();
        se = 1'b0;
        repeat (5) cycle();
        se = 1'b1;
        repeat (7) cycle();

        // Back-to-back words with load_valid held.
        lv = 1'b1; ld = 8'hA5;
        cycle();
        ld = 8'h3C;
        repeat (8) cycle();
        lv = 1'b0;
        repeat (9) cycle();

        // A load request in the middle of a word is ignored.
        lv = 1'b1; ld = 8'h00;
        cycle();
        lv = 1'b0;
        repeat (2) cycle();
        lv = 1'b1; ld = 8'hFF;
        cycle();
        lv = 1'b0;
        repeat (7) cycle();

        // Reset in the middle of a word, then a new word.
        lv = 1'b1; ld = 8'hA5;
        cycle();
        lv = 1'b0;
        repeat (4) cycle();
        reset_n = 1'b0;
        #1;
        check_reset("midreset");
        q_m.delete();
        q_l.delete();
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        lv = 1'b1; ld = 8'h81;
        cycle();
        lv = 1'b0;
        repeat (9) cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            lv = ($urandom_range(0, 9) < 7);
            ld = W'($urandom);
            se = ($urandom_range(0, 9) < 6);
            cycle();
        end
        lv = 1'b0; se = 1'b1;
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
